// File: rtl/pps_time_core.sv
// pps_time_core: PPS-domain timekeeping core.
// Holds a 64-bit timestamp with fractional rate trim, captures it on external
// events, generates a programmable PPS pulse and serves register commands
// popped from the system-to-PPS FIFO, pushing read data to the return FIFO.
//
// state   | meaning
// S_IDLE  | waiting for a command; pops one when the command FIFO is not empty
// S_FETCH | popped command word is valid; writes commit, reads are captured
// S_RESP  | read data held in rsp_data until the response FIFO accepts it
module pps_time_core #(
  parameter logic [31:0] TIME_INCR_VAL = 32'd10,
  parameter logic [31:0] PPS_COUNT_RST = 32'd120000000,
  parameter int unsigned PULSE_W       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [35:0] cmd_data,
  input  logic        cmd_empty,
  output logic        cmd_rd_en,
  output logic [31:0] rsp_data,
  input  logic        rsp_full,
  output logic        rsp_wr_en,
  input  logic        event_in,
  input  logic        pps_in,
  output logic        pps_pulse_out
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

  localparam logic [31:0] PULSE_W_L = 32'(PULSE_W);

  state_t      state;
  logic [63:0] ts;
  logic [63:0] ev;
  logic [31:0] accum;
  logic [31:0] accum_incr;
  logic [31:0] time_incr;
  logic [31:0] pps_count;
  logic [31:0] pps_ctr;
  logic [31:0] ts_shadow;
  logic [31:0] ev_shadow;
  logic        event_seen;
  logic        pps_seen;
  logic [1:0]  ev_sync;
  logic        ev_d;
  logic [1:0]  pps_sync;
  logic        pps_d;

  logic        ev_edge;
  logic        pps_edge;
  logic        cmd_wr;
  logic [2:0]  cmd_addr;
  logic        do_wr;
  logic        do_rd;
  logic        wr_pps_count;
  logic [32:0] accum_sum;
  logic [31:0] rd_val;

  assign ev_edge      = ev_sync[1] & ~ev_d;
  assign pps_edge     = pps_sync[1] & ~pps_d;
  assign cmd_wr       = cmd_data[35];
  assign cmd_addr     = cmd_data[34:32];
  assign do_wr        = (state == S_FETCH) & cmd_wr;
  assign do_rd        = (state == S_FETCH) & ~cmd_wr;
  assign wr_pps_count = do_wr & (cmd_addr == 3'd3);
  assign accum_sum    = {1'b0, accum} + {1'b0, accum_incr};

  // Pop and push strobes are decoded from state so that the popped word is
  // valid in FETCH and the push lands two cycles after the pop; the pop is
  // also gated by reset so it stays low while the core is held in reset.
  assign cmd_rd_en = reset_n & (state == S_IDLE) & ~cmd_empty;
  assign rsp_wr_en = (state == S_RESP) & ~rsp_full;

  // Two-flop synchronizers plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_sync  <= 2'b00;
      ev_d     <= 1'b0;
      pps_sync <= 2'b00;
      pps_d    <= 1'b0;
    end else begin
      ev_sync  <= {ev_sync[0], event_in};
      ev_d     <= ev_sync[1];
      pps_sync <= {pps_sync[0], pps_in};
      pps_d    <= pps_sync[1];
    end
  end

  // Timestamp advance: integer increment plus carry out of the trim accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum <= 32'd0;
      ts    <= 64'd0;
    end else begin
      accum <= accum_sum[31:0];
      ts    <= ts + {32'd0, time_incr} + {63'd0, accum_sum[32]};
    end
  end

  // Event capture and sticky status flags; a new edge wins over clear-on-read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev         <= 64'd0;
      event_seen <= 1'b0;
      pps_seen   <= 1'b0;
    end else begin
      if (ev_edge) begin
        ev         <= ts;
        event_seen <= 1'b1;
      end else if (do_rd && cmd_addr == 3'd7) begin
        event_seen <= 1'b0;
      end
      if (pps_edge) begin
        pps_seen <= 1'b1;
      end else if (do_rd && cmd_addr == 3'd7) begin
        pps_seen <= 1'b0;
      end
    end
  end

  // Writable configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum_incr <= 32'd0;
      pps_count  <= PPS_COUNT_RST;
      time_incr  <= TIME_INCR_VAL;
    end else if (do_wr) begin
      case (cmd_addr)
        3'd2:    accum_incr <= cmd_data[31:0];
        3'd3:    pps_count  <= cmd_data[31:0];
        3'd4:    time_incr  <= cmd_data[31:0];
        default: ;
      endcase
    end
  end

  // PPS period counter and registered pulse; the >= compare lets a shrunken
  // period wrap cleanly instead of running up to 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pps_ctr       <= 32'd0;
      pps_pulse_out <= 1'b0;
    end else begin
      pps_pulse_out <= (pps_count != 32'd0) && (pps_ctr < PULSE_W_L);
      if (pps_count == 32'd0 || pps_edge || wr_pps_count) begin
        pps_ctr <= 32'd0;
      end else if (pps_ctr >= pps_count - 32'd1) begin
        pps_ctr <= 32'd0;
      end else begin
        pps_ctr <= pps_ctr + 32'd1;
      end
    end
  end

  // Read data multiplexer, evaluated on the FETCH cycle.
  always_comb begin
    rd_val = 32'd0;
    case (cmd_addr)
      3'd0: rd_val = ts[31:0];
      3'd1: rd_val = ts_shadow;
      3'd2: rd_val = accum_incr;
      3'd3: rd_val = pps_count;
      3'd4: rd_val = time_incr;
      3'd5: rd_val = ev[31:0];
      3'd6: rd_val = ev_shadow;
      3'd7: rd_val = {30'd0, pps_seen, event_seen};
      default: rd_val = 32'd0;
    endcase
  end

  // Command FSM; low-word reads latch the matching high word into its shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rsp_data  <= 32'd0;
      ts_shadow <= 32'd0;
      ev_shadow <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!cmd_empty) state <= S_FETCH;
        end
        S_FETCH: begin
          if (cmd_wr) begin
            state <= S_IDLE;
          end else begin
            rsp_data <= rd_val;
            if (cmd_addr == 3'd0) ts_shadow <= ts[63:32];
            if (cmd_addr == 3'd5) ev_shadow <= ev[63:32];
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (!rsp_full) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pps_time_core.sv
// Directed bench for pps_time_core: register reads/writes through a modelled
// command FIFO, timestamp rate, event capture, PPS generation and back-pressure.
module tb_pps_time_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [35:0] cmd_data;
  logic        cmd_empty;
  logic        cmd_rd_en;
  logic [31:0] rsp_data;
  logic        rsp_full;
  logic        rsp_wr_en;
  logic        event_in;
  logic        pps_in;
  logic        pps_pulse_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pps_time_core dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_data      (cmd_data),
    .cmd_empty     (cmd_empty),
    .cmd_rd_en     (cmd_rd_en),
    .rsp_data      (rsp_data),
    .rsp_full      (rsp_full),
    .rsp_wr_en     (rsp_wr_en),
    .event_in      (event_in),
    .pps_in        (pps_in),
    .pps_pulse_out (pps_pulse_out)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; with time_incr=10 and no trim, ts = 10*cyc.
  always @(posedge clk) if (reset_n) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command through the FIFO model; fcyc is cyc during the FETCH cycle.
  task automatic bus_cmd(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int fcyc);
    logic got;
    got   = 1'b0;
    rdata = 32'd0;
    @(negedge clk);
    cmd_data  = {wr, addr, wdata};
    cmd_empty = 1'b0;
    #1;
    chk("pop_strobe", {63'd0, cmd_rd_en}, 64'd1);
    @(posedge clk);
    #1;
    cmd_empty = 1'b1;
    fcyc = cyc;
    if (wr) begin
      @(posedge clk);
    end else begin
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (rsp_wr_en) begin
          rdata = rsp_data;
          got   = 1'b1;
        end
      end
      if (!got) chk("rsp_timeout", 64'd0, 64'd1);
    end
  endtask

  logic [31:0] rd, rd2, t1, t2, pdata;
  int          fc, fc2, c1, c2, ev_base, high_cnt, push_cnt;
  logic        prev, found, last, any_wr, any_rd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    cmd_empty = 1'b1;
    cmd_data  = 36'd0;
    rsp_full  = 1'b0;
    event_in  = 1'b0;
    pps_in    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_wr_en", {63'd0, rsp_wr_en}, 64'd0);
    chk("rst_cmd_rd_en", {63'd0, cmd_rd_en}, 64'd0);
    chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("rst_pulse", {63'd0, pps_pulse_out}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_pulse", {63'd0, pps_pulse_out}, 64'd1);

    // Timestamp low/high words and rate
    bus_cmd(1'b0, 3'd0, 32'd0, rd, fc);
    chk("ts_lo", {32'd0, rd}, 64'(10 * fc));
    bus_cmd(1'b0, 3'd1, 32'd0, rd2, fc2);
    chk("ts_hi", {32'd0, rd2}, 64'd0);
    bus_cmd(1'b0, 3'd0, 32'd0, rd2, fc2);
    chk("ts_delta", {32'd0, rd2 - rd}, 64'(10 * (fc2 - fc)));
    bus_cmd(1'b0, 3'd4, 32'd0, rd, fc);
    chk("time_incr_rst", {32'd0, rd}, 64'd10);

    // Event capture: latched on the third clock edge after event_in rises
    @(negedge clk);
    event_in = 1'b1;
    ev_base  = cyc;
    repeat (6) @(negedge clk);
    event_in = 1'b0;
    bus_cmd(1'b0, 3'd5, 32'd0, rd, fc);
    chk("ev_lo", {32'd0, rd}, 64'(10 * (ev_base + 2)));
    bus_cmd(1'b0, 3'd6, 32'd0, rd, fc);
    chk("ev_hi", {32'd0, rd}, 64'd0);
    bus_cmd(1'b0, 3'd7, 32'd0, rd, fc);
    chk("flags_event", {32'd0, rd}, 64'd1);
    bus_cmd(1'b0, 3'd7, 32'd0, rd, fc);
    chk("flags_event_clr", {32'd0, rd}, 64'd0);

    // PPS generator with period 100
    bus_cmd(1'b1, 3'd3, 32'd100, rd, fc);
    found = 1'b0;
    prev  = pps_pulse_out;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (pps_pulse_out && !prev) found = 1'b1;
      prev = pps_pulse_out;
    end
    chk("pps_rise_found", {63'd0, found}, 64'd1);
    high_cnt = 0;
    last     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      if (pps_pulse_out) high_cnt++;
      last = pps_pulse_out;
    end
    @(negedge clk);
    chk("pps_high_cnt", 64'(high_cnt), 64'd16);
    chk("pps_period_edge", {62'd0, last, pps_pulse_out}, 64'd1);

    // pps_in edge mid-period restarts the pulse
    repeat (48) @(negedge clk);
    pps_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("pps_restart_low", {63'd0, pps_pulse_out}, 64'd0);
    @(negedge clk);
    chk("pps_restart_high", {63'd0, pps_pulse_out}, 64'd1);
    pps_in = 1'b0;
    bus_cmd(1'b0, 3'd7, 32'd0, rd, fc);
    chk("flags_pps", {32'd0, rd}, 64'd2);
    bus_cmd(1'b0, 3'd7, 32'd0, rd, fc);
    chk("flags_pps_clr", {32'd0, rd}, 64'd0);

    // Fractional trim: quarter-unit per clock over exactly 400 clocks
    bus_cmd(1'b1, 3'd2, 32'h4000_0000, rd, fc);
    bus_cmd(1'b0, 3'd0, 32'd0, t1, c1);
    while (cyc != c1 + 398) @(negedge clk);
    bus_cmd(1'b0, 3'd0, 32'd0, t2, c2);
    chk("accum_delta", {32'd0, t2 - t1}, 64'd4100);
    bus_cmd(1'b0, 3'd2, 32'd0, rd, fc);
    chk("accum_incr_rd", {32'd0, rd}, 64'h4000_0000);

    // Back-pressure: response FIFO full during a read of time_incr
    @(negedge clk);
    rsp_full  = 1'b1;
    cmd_data  = {1'b0, 3'd4, 32'd0};
    cmd_empty = 1'b0;
    @(posedge clk);
    any_wr = 1'b0;
    any_rd = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_wr |= rsp_wr_en;
      any_rd |= cmd_rd_en;
    end
    chk("full_no_push", {63'd0, any_wr}, 64'd0);
    chk("full_no_pop", {63'd0, any_rd}, 64'd0);
    rsp_full  = 1'b0;
    cmd_empty = 1'b1;
    push_cnt  = 0;
    pdata     = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (rsp_wr_en) begin
        push_cnt++;
        pdata = rsp_data;
      end
    end
    chk("full_push_cnt", 64'(push_cnt), 64'd1);
    chk("full_push_data", {32'd0, pdata}, 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pps_time_core.md
# pps_time_core

Timekeeping core of the PPS timer, clocked entirely in the fast PPS clock domain. It holds a 64-bit timestamp with fractional rate trim, captures the timestamp on external events, and generates a programmable pulse-per-second output. Register accesses arrive as 36-bit command words from the system-to-PPS clock-crossing FIFO, and read data leaves through the PPS-to-system FIFO. All CPU-visible behaviour of the PPS timer is defined here.

## Interface
- TIME_INCR_VAL, 10: reset value of time_incr (time units added per clk).
- PPS_COUNT_RST, 120000000: reset value of pps_count (clk cycles per output period).
- PULSE_W, 16: pps_pulse_out high time in clk cycles (1..255).
- clk  in  1  PPS-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_data  in  36  command from FIFO: [35]=is_write, [34:32]=word addr, [31:0]=write data; valid the cycle after cmd_rd_en.
- cmd_empty  in  1  command FIFO empty.
- cmd_rd_en  out  1  command FIFO pop strobe.
- rsp_data  out  32  read data to response FIFO.
- rsp_full  in  1  response FIFO full.
- rsp_wr_en  out  1  response FIFO push strobe.
- event_in  in  1  asynchronous event input.
- pps_in  in  1  asynchronous external PPS reference.
- pps_pulse_out  out  1  generated PPS pulse.

## Operation
- Register map (word addr):
  - 0: read = ts[31:0]; the same read latches ts[63:32] into ts_shadow.
  - 1: read = ts_shadow.
  - 2: accum_incr, read/write.
  - 3: pps_count, read/write.
  - 4: time_incr, read/write.
  - 5: read = ev[31:0]; the same read latches ev[63:32] into ev_shadow.
  - 6: read = ev_shadow.
  - 7: read = {30'b0, pps_seen, event_seen}, clear-on-read.
  - Writes to 0, 1, 5, 6 and 7 are ignored.
- Timestamp update, every clk:
  - {carry, accum} = accum + accum_incr (32-bit accumulator).
  - ts <= ts + time_incr + carry. 64-bit arithmetic, wraps modulo 2^64.
- event_in and pps_in each pass through a 2-flop synchronizer followed by a rising-edge detector.
- Event edge: ev <= ts value of that cycle (before the increment); event_seen <= 1.
- PPS generator:
  - pps_ctr counts 0..pps_count-1, then wraps.
  - pps_pulse_out is high while pps_ctr < PULSE_W.
  - If pps_count == 0, pps_ctr is held at 0 and the pulse is off.
  - A pps_in edge forces pps_ctr to 0, which restarts the pulse, and sets pps_seen.
  - A write to addr 3 forces pps_ctr to 0.
- Command FSM:
  - IDLE: if !cmd_empty, assert cmd_rd_en for one cycle and go to FETCH.
  - FETCH: cmd_data is valid. A write updates the register at the end of this cycle and returns to IDLE. A read captures the read value into rsp_data and goes to RESP.
  - RESP: when !rsp_full, assert rsp_wr_en for one cycle and go to IDLE; otherwise hold rsp_data and wait.

## Timing
- Reset values: all outputs 0; ts, accum, ev, both shadows, pps_ctr, accum_incr, and both flags = 0; time_incr = TIME_INCR_VAL; pps_count = PPS_COUNT_RST.
- The first pulse after reset starts 1 cycle after reset release (pps_ctr = 0).
- Command throughput: 1 command per 2 cycles for writes; 3 cycles minimum for reads.
- Read response: rsp_wr_en is asserted 2 cycles after cmd_rd_en when the response FIFO is not full.
- Written values take effect on the cycle after FETCH.
- Event capture latency: the ts latched is from 3 clk cycles after the event_in edge (2 synchronizer stages plus the edge stage).
- Simultaneous cases:
  - Event edge in the same cycle as an addr-7 read: the read returns the old flag, and the flag ends at 1 (set wins).
  - pps_in edge in the same cycle as a pps_count write: pps_ctr = 0, new pps_count is used.
  - Event edge in the cycle an addr-5 read is in FETCH: the read returns the old ev[31:0] and ev_shadow gets the old ev[63:32], so the pair stays coherent.
- rsp_full held high: FSM stays in RESP indefinitely; cmd_rd_en stays low.
- Reset mid-command: FSM returns to IDLE and no response is pushed; the FIFOs are reset alongside.

## Test plan
- Reset, then time_incr = 10, accum_incr = 0; read addr 0, then addr 1 -> consecutive reads differ by 10 × elapsed cycles; high word 0.
- accum_incr = 0x40000000 -> exactly one extra unit added per 4 cycles; over 400 cycles ts advances by 4100.
- pps_count = 100, no pps_in -> pps_pulse_out is high for 16 cycles out of every 100, with period exactly 100.
- pps_in edge at pps_ctr = 50 -> pulse restarts 3 cycles after the edge; addr 7 reads 0x2, then reads 0x0 on the next read.
- event_in edge, then read addr 5 and addr 6 -> value equals ts of the third cycle after the edge; addr 7 reads 0x1.
- Hold rsp_full = 1 during a read of addr 4 -> no rsp_wr_en and no cmd_rd_en; after release, a single push of 10.
